dm_ctrl: RTL and testbench

- Next-generation byte-addressable data memory for the single-cycle/multi-cycle MIPS datapath.
- Adds byte, halfword and word loads/stores with sign/zero extension and a parametrised depth.
- Adds a programmable wait-state counter behind a req/ack handshake, and alignment checking with an error response.
- Sits between the ALU address output and the register-file write-back mux; the control unit stalls on busy.

---
 rtl/dm_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dm_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// Byte-addressable data memory with programmable wait states, req/ack handshake,
// byte/half/word access with sign/zero extension and alignment error response.
module dm_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                capture, access;

  logic [ADDR_W-1:0]   addr_q;
  logic                we_q, sext_q;
  logic [1:0]          size_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic [7:0]          mem_q [Depth];

  logic [ADDR_W-1:0]   a0, a1, a2, a3;
  logic [7:0]          b0, b1, b2, b3;
  logic                err;
  logic [31:0]         load_data;

  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W];

  // Aligned accesses never cross the top, so OR-ing the lane offset is enough.
  assign a0 = addr_q;
  assign a1 = addr_q | ADDR_W'(1);
  assign a2 = addr_q | ADDR_W'(2);
  assign a3 = addr_q | ADDR_W'(3);
  assign b0 = mem_q[a0];
  assign b1 = mem_q[a1];
  assign b2 = mem_q[a2];
  assign b3 = mem_q[a3];

  always_comb begin
    err = 1'b0;
    case (size_q)
      2'b01:   err = addr_q[0];
      2'b10:   err = |addr_q[1:0];
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
  end

  always_comb begin
    load_data = '0;
    case (size_q)
      2'b00:   load_data = {{24{sext_q & b0[7]}}, b0};
      2'b01:   load_data = {{16{sext_q & b1[7]}}, b1, b0};
      2'b10:   load_data = {b3, b2, b1, b0};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          capture = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        // The RESP->IDLE edge doubles as the next request's sample point, so a
        // held req gives one access every LATENCY+2 cycles.
        if (req) begin
          capture = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = StWait;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= addr[ADDR_W-1:0];
        we_q    <= we;
        size_q  <= size;
        sext_q  <= sign_ext;
        wdata_q <= wdata;
      end
      if (access) begin
        err_q <= err;
        if (err) begin
          rdata_q <= '0;
        end else if (!we_q) begin
          rdata_q <= load_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (access && we_q && !err) begin
      mem_q[a0] <= wdata_q[7:0];
      if (size_q != 2'b00) begin
        mem_q[a1] <= wdata_q[15:8];
      end
      if (size_q == 2'b10) begin
        mem_q[a2] <= wdata_q[23:16];
        mem_q[a3] <= wdata_q[31:24];
      end
    end
  end

  assign rdata    = rdata_q;
  assign ack      = (state_q == StResp);
  assign busy     = (state_q != StIdle);
  assign addr_err = ack & err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: table of accesses checked through a scoreboard,
// plus hand sequences for reset-abort and back-to-back handshake.
module tb_dm_ctrl;

  localparam int unsigned AddrW = 10;
  localparam int unsigned Lat   = 1;

  logic        clk, rst;
  logic        req, req0, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata0;
  logic        ack, busy, addr_err, ack0, busy0, addr_err0;

  int checks = 0;
  int errors = 0;

  dm_ctrl #(.ADDR_W(AddrW), .LATENCY(Lat)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
    .addr_err(addr_err)
  );

  dm_ctrl #(.ADDR_W(AddrW), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .ack(ack0), .busy(busy0),
    .addr_err(addr_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected response.
  always @(negedge clk) begin
    if (rst && ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack: got ack=1 expected ack=0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_rdata", rdata, e.rd);
        check("sb_addr_err", 32'(addr_err), 32'(e.err));
      end
    end
  end

  task automatic do_access(input vec_t v, input int idx);
    int  c;
    int  bcnt;
    bit  seen;
    @(negedge clk);
    req = 1'b1; we = v.we; size = v.size; sign_ext = v.sext; addr = v.addr; wdata = v.wdata;
    sb_q.push_back('{rd: v.rd, err: v.err});
    @(posedge clk);
    #1;
    req = 1'b0;
    // Scramble inputs during WAIT; the latched request must not care.
    addr = $urandom; wdata = $urandom; size = 2'($urandom); we = 1'($urandom);
    sign_ext = 1'($urandom);
    c = 0; bcnt = 0; seen = 0;
    while (c < 20 && !seen) begin
      @(negedge clk);
      c++;
      if (busy) bcnt++;
      if (ack) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout vec%0d: got no ack expected ack within 20 cycles", idx);
    end else begin
      check($sformatf("ack_latency vec%0d", idx), 32'(c), 32'(Lat + 2));
      check($sformatf("busy_cycles vec%0d", idx), 32'(bcnt), 32'(Lat + 2));
      @(negedge clk);
      check($sformatf("busy_after vec%0d", idx), 32'(busy), 32'd0);
    end
  endtask

  task automatic abort_by_reset(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = 2'b10; sign_ext = 1'b0; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("mid_wait_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_ack_after_abort", 32'(ack), 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h20,       32'h80FF7F01, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h20,       32'h0,        32'h00000001, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h22,       32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h23,       32'h0,        32'h00000080, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h22,       32'h0,        32'hFFFF80FF, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h20,       32'h0,        32'h00007F01, 1'b0};
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h40,       32'h11223344, 32'h00007F01, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h41,       32'h123456AA, 32'h00007F01, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h42,       32'h5555BEEF, 32'h00007F01, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 1'b1, 32'h40,       32'h0,        32'hBEEFAA44, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h41,       32'h0,        32'h00000000, 1'b1};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h43,       32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h40,       32'h0,        32'h00000000, 1'b1};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        32'hBEEFAA44, 1'b0};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h400,      32'h12345678, 32'hBEEFAA44, 1'b0};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h000,      32'h0,        32'h12345678, 1'b0};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'hFFFFF400, 32'h0,        32'h12345678, 1'b0};
    vecs[17] = '{1'b0, 2'b01, 1'b1, 32'h41,       32'h0,        32'h00000000, 1'b1};

    req = 1'b0; req0 = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    rst = 1'b1;

    // Reset mid-WAIT of a load, then a clean word load from cleared memory.
    abort_by_reset(1'b0, 32'h10, 32'h0);
    do_access('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0}, 100);

    for (int i = 0; i < 18; i++) begin
      do_access(vecs[i], i);
    end

    // Reset mid-store: the store is dropped and memory is cleared.
    abort_by_reset(1'b1, 32'h80, 32'hDEADBEEF);
    do_access('{1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0}, 101);
    do_access('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0}, 102);

    // LATENCY=0 instance with req held high: store then loads, one per 2 cycles.
    @(negedge clk);
    req0 = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h8; wdata = 32'hCAFEF00D;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ack%0d", i), 32'(ack0), 32'((i % 2) == 1));
      check($sformatf("b2b_busy%0d", i), 32'(busy0), 32'd1);
      if (ack0) begin
        check($sformatf("b2b_rdata%0d", i), rdata0, (i == 1) ? 32'h0 : 32'hCAFEF00D);
        check($sformatf("b2b_err%0d", i), 32'(addr_err0), 32'd0);
      end
      if (i == 1) we = 1'b0;
      if (i == 7) req0 = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", 32'(busy0), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

endmodule
